// File: rtl/inv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inv_pkg
// Brief    : Shared constants, FSM encoding and word-select helper for inv_result_tx
// Revision : 1.0 - initial release
// ============================================================================
package inv_pkg;

    localparam int WORDS_PER_MAT = 8;
    localparam int TX_W          = 32;
    localparam int CNT_W         = 16;
    localparam int IDX_W         = $clog2(WORDS_PER_MAT);
    localparam int MAT_W         = WORDS_PER_MAT * TX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // Word 0 is the most significant slice of {A11, A12, A21, A22}.
    function automatic logic [TX_W-1:0] mat_word(input logic [MAT_W-1:0] mat,
                                                 input logic [IDX_W-1:0] idx);
        return mat[(WORDS_PER_MAT - 1 - int'(idx)) * TX_W +: TX_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mat_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mat_fifo
// Brief    : Synchronous FIFO of whole matrices, extra pointer bit for full/empty
// Revision : 1.0 - initial release
// ============================================================================
module mat_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/inv_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : inv_result_tx
// Brief    : Buffers inverse matrices and serialises each as eight 32-bit words
// Revision : 1.0 - initial release
// ============================================================================
module inv_result_tx
    import inv_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ELEM_W = 64
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic [ELEM_W-1:0] I_A11_inv,
    input  logic [ELEM_W-1:0] I_A12_inv,
    input  logic [ELEM_W-1:0] I_A21_inv,
    input  logic [ELEM_W-1:0] I_A22_inv,
    input  logic              I_A_inv_valid,
    output logic [TX_W-1:0]   O_tx_data,
    output logic              O_tx_valid,
    input  logic              I_tx_ready,
    output logic              O_tx_last,
    output logic              O_overflow,
    output logic [CNT_W-1:0]  O_drop_cnt,
    output logic [CNT_W-1:0]  O_tx_cnt
);

    localparam int                 ENTRY_W  = 4 * ELEM_W;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS_PER_MAT - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [ENTRY_W-1:0] r_hold;
    logic [ENTRY_W-1:0] w_hold_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [TX_W-1:0]    r_tx_data;
    logic [TX_W-1:0]    w_data_nxt;
    logic               r_tx_valid;
    logic               w_valid_nxt;
    logic               r_tx_last;
    logic               w_last_nxt;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   r_tx_cnt;

    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_sent;

    assign w_entry   = {I_A11_inv, I_A12_inv, I_A21_inv, I_A22_inv};
    assign w_idx_inc = r_idx + 1'b1;
    assign w_push    = I_A_inv_valid && (!w_fifo_full || w_pop);
    assign w_drop    = I_A_inv_valid && !w_push;

    mat_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mat_fifo (
        .clk     (I_sys_clk),
        .rst     (I_sys_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers always hold the word at r_idx while r_tx_valid is set;
    // the first SEND cycle after IDLE only loads them from the holding register.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_tx_data;
        w_valid_nxt = r_tx_valid;
        w_last_nxt  = r_tx_last;
        w_pop       = 1'b0;
        w_sent      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = w_fifo_dout;
                    w_idx_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!r_tx_valid) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = mat_word(r_hold, r_idx);
                    w_last_nxt  = (r_idx == LAST_IDX);
                end else if (I_tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_sent = 1'b1;
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_hold_nxt  = w_fifo_dout;
                            w_idx_nxt   = '0;
                            w_data_nxt  = mat_word(w_fifo_dout, '0);
                            w_last_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_valid_nxt = 1'b0;
                            w_data_nxt  = '0;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_data_nxt = mat_word(r_hold, w_idx_inc);
                        w_last_nxt = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_hold     <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_tx_cnt   <= '0;
        end else begin
            r_hold     <= w_hold_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_last  <= w_last_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {CNT_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
            if (w_sent) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign O_tx_data  = r_tx_data;
    assign O_tx_valid = r_tx_valid;
    assign O_tx_last  = r_tx_last;
    assign O_overflow = r_overflow;
    assign O_drop_cnt = r_drop_cnt;
    assign O_tx_cnt   = r_tx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inv_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_result_tx
// Brief    : Directed self-checking bench for inv_result_tx
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_result_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a11, a12, a21, a22;
    logic        vld;
    logic        rdy;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] tx_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned cyc_no = 0;
    logic [31:0] q_data [$];
    logic        q_last [$];
    int unsigned q_cyc  [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    inv_result_tx #(
        .DEPTH  (4),
        .ELEM_W (64)
    ) dut (
        .I_sys_clk     (clk),
        .I_sys_rst     (rst),
        .I_A11_inv     (a11),
        .I_A12_inv     (a12),
        .I_A21_inv     (a21),
        .I_A22_inv     (a22),
        .I_A_inv_valid (vld),
        .O_tx_data     (tx_data),
        .O_tx_valid    (tx_valid),
        .I_tx_ready    (rdy),
        .O_tx_last     (tx_last),
        .O_overflow    (overflow),
        .O_drop_cnt    (drop_cnt),
        .O_tx_cnt      (tx_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Records every handshake and checks that a stalled word does not move.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                assert (tx_valid === 1'b1 && tx_data === prev_data && tx_last === prev_last)
                else begin
                    n_bad++;
                    $error("FAIL hold_stable: observed v=%b d=%h l=%b expected v=1 d=%h l=%b",
                           tx_valid, tx_data, tx_last, prev_data, prev_last);
                end
            end
            if (tx_valid === 1'b1 && rdy === 1'b1) begin
                q_data.push_back(tx_data);
                q_last.push_back(tx_last);
                q_cyc.push_back(cyc_no);
            end
            prev_stall <= (tx_valid === 1'b1) && (rdy === 1'b0);
            prev_data  <= tx_data;
            prev_last  <= tx_last;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int k);
        logic [31:0] t;
        t = 32'(k);
        return {t, 32'h11, t, 32'h12, t, 32'h21, t, 32'h22};
    endfunction

    task automatic drive(input logic [255:0] m);
        a11 = m[255:192];
        a12 = m[191:128];
        a21 = m[127:64];
        a22 = m[63:0];
        vld = 1'b1;
    endtask

    task automatic push(input logic [255:0] m);
        drive(m);
        cyc(1);
        vld = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Checks 8 recorded words starting at queue slot 'first' against matrix m.
    task automatic chk_mat(input string tag, input int first, input logic [255:0] m);
        logic [31:0] obs_w;
        logic        obs_l;
        logic [31:0] exp_w;
        for (int i = 0; i < 8; i++) begin
            obs_w = (first + i < q_data.size()) ? q_data[first + i] : 32'hxxxx_xxxx;
            obs_l = (first + i < q_last.size()) ? q_last[first + i] : 1'bx;
            exp_w = m[255 - 32*i -: 32];
            chk($sformatf("%s_w%0d", tag, i), 64'(obs_w), 64'(exp_w));
            chk($sformatf("%s_l%0d", tag, i), 64'(obs_l), 64'(i == 7));
        end
    endtask

    initial begin
        logic [255:0] m1;
        logic [31:0]  exp1 [8];
        logic [255:0] mb;
        int           n_last;

        rst = 1'b1;
        vld = 1'b0;
        rdy = 1'b1;
        a11 = '0; a12 = '0; a21 = '0; a22 = '0;
        cyc(2);

        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data",  64'(tx_data),  64'd0);
        chk("rst_last",  64'(tx_last),  64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        chk("rst_txcnt", 64'(tx_cnt),   64'd0);
        rst = 1'b0;
        cyc(1);

        // Single matrix, ready high, latency and word order
        m1 = {64'h0000_0001_0000_0002, 64'h0000_0000_0000_0003,
              64'hFFFF_FFFF_0000_0000, 64'h0000_0000_0000_0000};
        exp1 = '{32'h00000001, 32'h00000002, 32'h00000000, 32'h00000003,
                 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};
        clear_q();
        push(m1);
        chk("lat_n0_valid", 64'(tx_valid), 64'd0);
        cyc(1);
        chk("lat_n1_valid", 64'(tx_valid), 64'd0);
        cyc(1);
        chk("lat_n2_valid", 64'(tx_valid), 64'd1);
        chk("lat_n2_data",  64'(tx_data),  64'h1);
        cyc(8);
        chk("single_idle", 64'(tx_valid), 64'd0);
        chk("single_nwords", 64'(q_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("single_w%0d", i),
                64'((i < q_data.size()) ? q_data[i] : 32'hxxxx_xxxx), 64'(exp1[i]));
            chk($sformatf("single_l%0d", i),
                64'((i < q_last.size()) ? q_last[i] : 1'bx), 64'(i == 7));
        end
        chk("single_txcnt", 64'(tx_cnt), 64'd1);

        // Backpressure with ready pattern 1,0,0
        mb = {64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444,
              64'h5555_5555_6666_6666, 64'h7777_7777_8888_8888};
        clear_q();
        rdy = 1'b0;
        push(mb);
        for (int i = 0; i < 45; i++) begin
            rdy = (i % 3 == 0);
            cyc(1);
        end
        rdy = 1'b1;
        cyc(4);
        chk("bp_nwords", 64'(q_data.size()), 64'd8);
        chk_mat("bp", 0, mb);
        n_last = 0;
        foreach (q_last[i]) if (q_last[i] === 1'b1) n_last++;
        chk("bp_nlast", 64'(n_last), 64'd1);
        chk("bp_txcnt", 64'(tx_cnt), 64'd2);

        // Burst of 6: one pops straight into holding, four fill the FIFO, one drops
        clear_q();
        for (int k = 0; k < 6; k++) begin
            drive(mk(k));
            cyc(1);
        end
        vld = 1'b0;
        cyc(45);
        chk("burst_nwords", 64'(q_data.size()), 64'd40);
        for (int k = 0; k < 5; k++) chk_mat($sformatf("burst_m%0d", k), 8*k, mk(k));
        chk("burst_contig", 64'((q_cyc.size() == 40) ? (q_cyc[39] - q_cyc[0]) : 0), 64'd39);
        chk("burst_ovf",   64'(overflow), 64'd1);
        chk("burst_drop",  64'(drop_cnt), 64'd1);
        chk("burst_txcnt", 64'(tx_cnt),   64'd7);

        // Reset clears sticky overflow and counters
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst2_ovf",   64'(overflow), 64'd0);
        chk("rst2_drop",  64'(drop_cnt), 64'd0);
        chk("rst2_txcnt", 64'(tx_cnt),   64'd0);

        // Full FIFO: push coincides with the last-word handshake
        clear_q();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(mk(k));
            cyc(1);
        end
        vld = 1'b0;
        chk("full_ovf_pre", 64'(overflow), 64'd0);
        chk("full_w0",      64'(tx_data),  64'h0);
        rdy = 1'b1;
        cyc(7);
        chk("full_last_now", 64'(tx_last), 64'd1);
        chk("full_data_now", 64'(tx_data), 64'h22);
        push(mk(5));
        cyc(45);
        chk("full_ovf",    64'(overflow), 64'd0);
        chk("full_drop",   64'(drop_cnt), 64'd0);
        chk("full_nwords", 64'(q_data.size()), 64'd48);
        for (int k = 0; k < 6; k++) chk_mat($sformatf("full_m%0d", k), 8*k, mk(k));
        chk("full_txcnt",  64'(tx_cnt), 64'd6);

        // Reset in the middle of word 3 with two matrices queued
        clear_q();
        for (int k = 0; k < 3; k++) begin
            drive(mk(k));
            cyc(1);
        end
        vld = 1'b0;
        cyc(3);
        chk("mid_w3_data", 64'(tx_data), 64'h12);
        chk("mid_w3_last", 64'(tx_last), 64'd0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(tx_valid), 64'd0);
        chk("mid_rst_data",  64'(tx_data),  64'd0);
        chk("mid_rst_last",  64'(tx_last),  64'd0);
        chk("mid_rst_txcnt", 64'(tx_cnt),   64'd0);
        clear_q();
        cyc(20);
        chk("mid_no_words", 64'(q_data.size()), 64'd0);
        chk("mid_idle",     64'(tx_valid), 64'd0);
        push(mk(7));
        cyc(12);
        chk("post_nwords", 64'(q_data.size()), 64'd8);
        chk_mat("post", 0, mk(7));
        chk("post_txcnt", 64'(tx_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
